// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   state_t     : scheduler FSM states (3-bit encoding)
//   REQ_KEYPAD  : requester index of the keypad scanner
//   REQ_SWITCH  : requester index of the switch/send-button path
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam logic REQ_KEYPAD = 1'b0;
  localparam logic REQ_SWITCH = 1'b1;

endpackage

// File: rtl/uart_tx_scheduler_slot.sv
// One-byte holding register for a single requester.
//   clk, rst : system clock, synchronous active-high reset
//   req/data : incoming byte strobe and value
//   free     : scheduler releases the held byte this cycle
//   ovr_clr  : clears the sticky overrun flag
//   full     : a byte is held
//   held     : the held byte
//   ack      : one-cycle acceptance pulse, one cycle after req
//   ovr      : sticky overrun flag (byte dropped while full)
module tx_hold_slot
  import uart_tx_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] data,
  input  logic       free,
  input  logic       ovr_clr,
  output logic       full,
  output logic [7:0] held,
  output logic       ack,
  output logic       ovr
);

  logic take;
  logic drop;

  // A slot being freed this cycle can take a new byte in the same cycle.
  always_comb begin
    take = req && (!full || free);
    drop = req && full && !free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      held <= '0;
      ack  <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      ack <= take;
      if (take) begin
        held <= data;
        full <= 1'b1;
      end else if (free) begin
        full <= 1'b0;
      end
      // A new overrun takes priority over a clear in the same cycle.
      if (drop)
        ovr <= 1'b1;
      else if (ovr_clr)
        ovr <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between the keypad
// scanner (requester 0) and the switch/send-button path (requester 1).
//   clk, rst         : system clock, synchronous active-high reset
//   req0/data0/ack0  : requester 0 byte strobe, byte, acceptance pulse
//   req1/data1/ack1  : requester 1 byte strobe, byte, acceptance pulse
//   tx_data/tx_start : byte and one-cycle start pulse to the transmitter
//   tx_busy          : transmitter busy (already in clk domain)
//   busy             : scheduler not idle
//   last_grant       : most recently granted requester
//   ovr/ovr_clr      : sticky per-requester overrun flags and their clear
//   tmo              : sticky "tx_busy never rose" flag, cleared by ovr_clr
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned BUSY_TIMEOUT = 8191
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       last_grant,
  output logic [1:0] ovr,
  input  logic       ovr_clr,
  output logic       tmo
);

  localparam int unsigned TW = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LOAD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] G_ONE  = GW'(1);

  state_t        state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [GW-1:0] gcnt, gcnt_nx;
  logic          lg_nx;
  logic [7:0]    txd_nx;
  logic          tmo_nx;
  logic          tmo_set;
  logic          frame_free;
  logic          pick;
  logic          full0, full1;
  logic [7:0]    held0, held1;
  logic          free0, free1;

  tx_hold_slot u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .req     (req0),
    .data    (data0),
    .free    (free0),
    .ovr_clr (ovr_clr),
    .full    (full0),
    .held    (held0),
    .ack     (ack0),
    .ovr     (ovr[REQ_KEYPAD])
  );

  tx_hold_slot u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .req     (req1),
    .data    (data1),
    .free    (free1),
    .ovr_clr (ovr_clr),
    .full    (full1),
    .held    (held1),
    .ack     (ack1),
    .ovr     (ovr[REQ_SWITCH])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      gcnt       <= '0;
      last_grant <= REQ_SWITCH;
      tx_data    <= '0;
      tmo        <= 1'b0;
    end else begin
      state      <= state_nx;
      tcnt       <= tcnt_nx;
      gcnt       <= gcnt_nx;
      last_grant <= lg_nx;
      tx_data    <= txd_nx;
      tmo        <= tmo_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tcnt_nx    = tcnt;
    gcnt_nx    = gcnt;
    lg_nx      = last_grant;
    txd_nx     = tx_data;
    tmo_set    = 1'b0;
    frame_free = 1'b0;
    pick       = last_grant;

    case (state)
      IDLE: begin
        if (full0 || full1) begin
          if (full0 && full1)
            pick = ~last_grant;
          else
            pick = full1 ? REQ_SWITCH : REQ_KEYPAD;
          lg_nx    = pick;
          txd_nx   = pick ? held1 : held0;
          state_nx = START;
        end
      end
      START: begin
        tcnt_nx  = '0;
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nx = WAIT_DONE;
        end else if (tcnt == T_LAST) begin
          tmo_set    = 1'b1;
          frame_free = 1'b1;
          gcnt_nx    = G_LOAD;
          state_nx   = GAP;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          frame_free = 1'b1;
          gcnt_nx    = G_LOAD;
          state_nx   = GAP;
        end
      end
      GAP: begin
        // Exits after GAP_CYCLES cycles; a zero load still spends one cycle here.
        if (gcnt <= G_ONE)
          state_nx = IDLE;
        else
          gcnt_nx = gcnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    tmo_nx = tmo_set || (tmo && !ovr_clr);
  end

  // last_grant names the slot in flight from START until the frame is freed.
  always_comb begin
    free0    = frame_free && (last_grant == REQ_KEYPAD);
    free1    = frame_free && (last_grant == REQ_SWITCH);
    tx_start = (state == START);
    busy     = (state != IDLE);
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter between two byte sources: requester 0 is the keypad scanner and requester 1 is the switch/send-button path. Each requester has a one-byte holding register. A round-robin arbiter picks the next byte and hands it to the transmitter with a start pulse. It then tracks the transmitter's busy signal to frame completion and enforces an inter-frame gap. It sits between the input sources and the TX FSM, in the system clock domain.

Parameters:
GAP_CYCLES, 16, idle clk cycles inserted after each frame before the next start (0 allowed = no gap)
BUSY_TIMEOUT, 8191, max clk cycles to wait for tx_busy to rise after tx_start before the frame is abandoned

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req0  in  1  requester 0 byte valid (single-cycle pulse)
data0  in  8  requester 0 byte
ack0  out  1  one-cycle pulse: byte from req0 accepted into holding register
req1  in  1  requester 1 byte valid (single-cycle pulse)
data1  in  8  requester 1 byte
ack1  out  1  one-cycle pulse: byte from req1 accepted
tx_data  out  8  byte presented to transmitter; stable from tx_start until frame done
tx_start  out  1  one-cycle start pulse to transmitter
tx_busy  in  1  transmitter busy (already synchronised to clk)
busy  out  1  high whenever state != IDLE
last_grant  out  1  index of most recently granted requester
ovr  out  2  sticky overrun flags per requester
ovr_clr  in  1  clears both ovr bits
tmo  out  1  sticky timeout flag, cleared by ovr_clr

Behaviour:
- Reset (rst=1 at a clk edge):
  - outputs: ack0/ack1/tx_start/busy/tmo = 0, ovr = 0, tx_data = 8'h00, last_grant = 1 (so req0 wins first tie)
  - holding registers empty, FSM -> IDLE, counters = 0
  - rst mid-frame aborts silently; no tx_start is reissued
- Capture, per requester i:
  - req_i=1 and holding empty (or being freed this cycle): latch data_i; ack_i=1 on the next cycle (1-cycle latency).
  - req_i=1 and holding full and not freed this cycle: byte dropped, ovr[i] set, no ack.
  - ovr_clr and a new overrun in the same cycle: the set wins.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
  - IDLE:
    - If any holding register is full, grant it.
    - If both are full, grant ~last_grant.
    - Load tx_data from the granted register, update last_grant, go to START.
    - A byte captured this cycle is not eligible until the next cycle.
  - START: tx_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy=1 -> WAIT_DONE.
    - Otherwise increment the counter. At BUSY_TIMEOUT: set tmo, free the granted holding register (byte discarded), go to GAP.
  - WAIT_DONE: tx_busy=0 -> free the granted holding register, load the gap counter, go to GAP.
  - GAP:
    - Count GAP_CYCLES cycles, then go to IDLE.
    - GAP_CYCLES=0 means go to IDLE on the next cycle.
- Free + req on the same requester in the same cycle: the new byte is captured, acked, and not flagged.
- A non-granted holding register is never modified by frame completion.
- tx_data holds its value after the frame until the next grant.
- Counter widths: $clog2(BUSY_TIMEOUT+1) and $clog2(GAP_CYCLES+1); neither wraps.
- Steady state with both requesters always full: grants alternate 0,1,0,1.

Decomposition:
- Shared package:
  - FSM state encoding (localparam enum, 3 bits)
  - requester index constants REQ_KEYPAD=0, REQ_SWITCH=1
- One natural sub-module: tx_hold_slot (8-bit holding register, full flag, ack generation, overrun detect). Instantiate it twice; the arbiter/FSM lives in the top.

Test Plan:
- Single request: req0 pulse with data0=8'h35, tx_busy raised 3 cycles after tx_start and held 100 cycles.
  -> ack0 1 cycle after req0; tx_start exactly once; tx_data=8'h35; busy drops GAP_CYCLES+1 cycles after tx_busy falls.
- Simultaneous requests: req0 (8'hA1) and req1 (8'hB2) in the same cycle after reset.
  -> 8'hA1 sent first, then 8'hB2; last_grant ends at 1.
  -> Repeat with both held full: grant order 0,1,0,1.
- Overrun: req1 8'h11 accepted, then req1 8'h22 while the first frame is in WAIT_DONE.
  -> no ack1 for the second byte; ovr=2'b10; only 8'h11 transmitted.
  -> ovr_clr -> ovr=0.
- Free/capture race: req0 8'h44 on the exact cycle tx_busy falls for the previous req0 frame.
  -> ack0 asserted, ovr[0]=0, 8'h44 sent next.
- Timeout: tx_busy held 0 after tx_start.
  -> tmo=1 after BUSY_TIMEOUT cycles; holding register freed; FSM reaches IDLE after the gap; a subsequent req is sent normally.
- Reset mid-frame: rst pulsed during WAIT_DONE with both slots full.
  -> all outputs at reset values the next cycle; no tx_start until a new req.
